// File: rtl/multi_channel_fifo.sv
// multi_channel_fifo: NUM_CHANNELS independent FIFO queues sharing one storage array
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   flush_mask                      per-channel synchronous flush, overrides enqueue/dequeue
//   enqueue_en/enqueue_channel/value_i   shared write port with channel select
//   dequeue_en/dequeue_channel/value_o   shared show-ahead read port with channel select
//   full/almost_full/empty/almost_empty  per-channel status, count packed NW bits per channel
//   overflow/underflow              sticky error flags
// Define MULTI_CHANNEL_FIFO_ERROR_CHECK_EN to drop and flag illegal accesses; without it the
// flags are tied low and illegal accesses are caught by simulation assertions only.
module multi_channel_fifo #(
    parameter int WIDTH                  = 64,
    parameter int SIZE                   = 4,
    parameter int NUM_CHANNELS           = 4,
    parameter int ALMOST_FULL_THRESHOLD  = SIZE,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
    localparam int NW = $clog2(SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CHANNELS-1:0]    flush_mask,
    input  logic                       enqueue_en,
    input  logic [CW-1:0]              enqueue_channel,
    input  logic [WIDTH-1:0]           value_i,
    input  logic                       dequeue_en,
    input  logic [CW-1:0]              dequeue_channel,
    output logic [WIDTH-1:0]           value_o,
    output logic [NUM_CHANNELS-1:0]    full,
    output logic [NUM_CHANNELS-1:0]    almost_full,
    output logic [NUM_CHANNELS-1:0]    empty,
    output logic [NUM_CHANNELS-1:0]    almost_empty,
    output logic [NUM_CHANNELS*NW-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(SIZE);
    localparam int DW = $clog2(NUM_CHANNELS * SIZE);
    localparam logic [NW-1:0] FULL_CNT = NW'(SIZE);
    localparam logic [NW-1:0] AF_CNT = NW'(ALMOST_FULL_THRESHOLD);
    localparam logic [NW-1:0] AE_CNT = NW'(ALMOST_EMPTY_THRESHOLD);

    logic [WIDTH-1:0] mem_q [NUM_CHANNELS*SIZE];
    logic [AW-1:0] head_q [NUM_CHANNELS];
    logic [AW-1:0] head_d [NUM_CHANNELS];
    logic [AW-1:0] tail_q [NUM_CHANNELS];
    logic [AW-1:0] tail_d [NUM_CHANNELS];
    logic [NW-1:0] cnt_q [NUM_CHANNELS];
    logic [NW-1:0] cnt_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_hit, udf_hit, do_enq, do_deq;

    // Depth need not be a power of two, so wrap by compare.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p == AW'(SIZE - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ovf_hit = '0;
        udf_hit = '0;
        do_enq = '0;
        do_deq = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            // A flushed channel ignores its traffic, so it cannot misbehave that cycle.
            ovf_hit[c] = enqueue_en && enqueue_channel == CW'(c) && cnt_q[c] == FULL_CNT
                         && !(dequeue_en && dequeue_channel == CW'(c)) && !flush_mask[c];
            udf_hit[c] = dequeue_en && dequeue_channel == CW'(c) && cnt_q[c] == '0 && !flush_mask[c];
`ifdef MULTI_CHANNEL_FIFO_ERROR_CHECK_EN
            do_enq[c] = enqueue_en && enqueue_channel == CW'(c) && !flush_mask[c] && !ovf_hit[c];
            do_deq[c] = dequeue_en && dequeue_channel == CW'(c) && !flush_mask[c] && !udf_hit[c];
`else
            do_enq[c] = enqueue_en && enqueue_channel == CW'(c) && !flush_mask[c];
            do_deq[c] = dequeue_en && dequeue_channel == CW'(c) && !flush_mask[c];
`endif
            head_d[c] = flush_mask[c] ? '0 : do_deq[c] ? ptr_inc(head_q[c]) : head_q[c];
            tail_d[c] = flush_mask[c] ? '0 : do_enq[c] ? ptr_inc(tail_q[c]) : tail_q[c];
            cnt_d[c] = flush_mask[c] ? '0 : cnt_q[c] + NW'(do_enq[c]) - NW'(do_deq[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                head_q[c] <= '0;
                tail_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++)
            if (do_enq[c]) mem_q[DW'(c * SIZE) + DW'(tail_q[c])] <= value_i;
    end

    always_comb begin
        value_o = '0;
        full = '0;
        almost_full = '0;
        empty = '0;
        almost_empty = '0;
        count = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            full[c] = cnt_q[c] == FULL_CNT;
            almost_full[c] = cnt_q[c] >= AF_CNT;
            empty[c] = cnt_q[c] == '0;
            almost_empty[c] = cnt_q[c] <= AE_CNT;
            count[c*NW +: NW] = cnt_q[c];
            if (dequeue_channel == CW'(c)) value_o = mem_q[DW'(c * SIZE) + DW'(head_q[c])];
        end
    end

`ifdef MULTI_CHANNEL_FIFO_ERROR_CHECK_EN
    logic ovf_q, ovf_d, udf_q, udf_d;
    assign ovf_d = ovf_q | (|ovf_hit);
    assign udf_d = udf_q | (|udf_hit);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
    assign overflow = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow = 1'b0;
    assign underflow = 1'b0;
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) ovf_hit == '0);
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) udf_hit == '0);
`endif
endmodule

// File: doc/multi_channel_fifo.md
# multi_channel_fifo

Parametrised synchronous FIFO holding NUM_CHANNELS independent queues in one storage array, with one shared enqueue port and one shared dequeue port. Each port carries a channel select. It is the successor to the single-queue synchronous FIFO. It is intended for per-thread or per-virtual-channel request buffering, for example L2 miss queues and IO request queues. Depth need not be a power of two, per-channel occupancy is exported, and illegal accesses can optionally be trapped.

## Interface
- WIDTH, 64, payload bits per entry
- SIZE, 4, entries per channel; any value ≥ 2, power of two not required
- NUM_CHANNELS, 4, independent queues; ≥ 1
- ALMOST_FULL_THRESHOLD, SIZE, almost_full[c] asserts when count[c] ≥ this value
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty[c] asserts when count[c] ≤ this value
- Derived: CW = max(1, $clog2(NUM_CHANNELS)), AW = $clog2(SIZE), NW = $clog2(SIZE+1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush_mask  in  NUM_CHANNELS  synchronous flush, one bit per channel
- enqueue_en  in  1  write value_i into enqueue_channel
- enqueue_channel  in  CW  target queue
- value_i  in  WIDTH  write data
- dequeue_en  in  1  pop head of dequeue_channel
- dequeue_channel  in  CW  source queue; also selects value_o
- value_o  out  WIDTH  head entry of dequeue_channel (show-ahead)
- full, almost_full, empty, almost_empty  out  NUM_CHANNELS each  per-channel status
- count  out  NUM_CHANNELS*NW  per-channel occupancy; channel c is at bits [c*NW +: NW]
- overflow, underflow  out  1 each  sticky error flags (see Configuration)

## Operation
- Storage is NUM_CHANNELS*SIZE words; channel c owns words c*SIZE .. c*SIZE+SIZE-1.
- Each channel has its own head pointer (AW bits), tail pointer (AW bits) and count (NW bits).
- A pointer increment wraps from SIZE-1 to 0 by explicit compare, not by natural overflow.
- full[c] = (count[c] == SIZE) and empty[c] = (count[c] == 0), both combinational from registers.
- Almost flags are compared at NW width. almost_full is implied by full when the threshold ≤ SIZE; almost_empty is implied by empty.
- value_o = storage[dequeue_channel*SIZE + head[dequeue_channel]], combinational. It is undefined when that channel is empty.
- Enqueue writes storage at the tail and advances the tail. Dequeue advances the head. Both act only on the selected channel.
- Same channel enqueued and dequeued in one cycle: head and tail both advance and count is unchanged. This is legal even when the channel is full, because the dequeue frees the slot.
- Different channels in one cycle: each channel updates independently, one count +1 and the other −1.
- Flush: when flush_mask[c]=1, channel c's head, tail and count go to 0. Flush overrides any enqueue or dequeue to that channel in the same cycle. Other channels proceed normally.
- Storage words are not reset.
- Reset (asynchronous): all heads, tails and counts go to 0, and overflow and underflow go to 0.
  - Output state after reset: empty = all 1s, almost_empty = all 1s, full = 0, and almost_full = 0 unless ALMOST_FULL_THRESHOLD is 0.
  - Reset asserted mid-operation discards all queued entries immediately.

## Timing
- Enqueue to visibility: an entry written at edge N is visible on value_o and in count after edge N, so it can be dequeued in cycle N+1.
- Status outputs and value_o are combinational from state registers; there is no input-to-output combinational path except dequeue_channel to value_o.
- Dequeue has zero latency: the data is on value_o during the cycle dequeue_en is asserted, and the next entry appears after the edge.
- There is no backpressure handshake. The caller must check full/empty for the selected channel before asserting enqueue_en/dequeue_en.

## Configuration
- MULTI_CHANNEL_FIFO_ERROR_CHECK_EN defined:
  - An enqueue to a full channel, without a same-cycle dequeue of that channel, is dropped and sets overflow.
  - A dequeue from an empty channel is dropped and sets underflow.
  - Both flags are sticky until reset; flush does not clear them.
  - The sibling operation in the same cycle still executes.
- Not defined:
  - overflow and underflow are tied to 0.
  - Illegal operations trigger an assert in simulation; behaviour in synthesis is undefined (pointers corrupt).

## Test plan
- Reset, then SIZE=4, NUM_CHANNELS=4: enqueue 0xA0..0xA3 into channel 2, dequeue from channel 2 → value_o reads 0xA0, 0xA1, 0xA2, 0xA3 in order; full[2] is 1 after the fourth enqueue; empty = 4'b1111 at the end.
- Interleave channels: enqueue 0x11 to channel 0 and 0x22 to channel 3 alternately, 3 each → count[0]=3, count[3]=3; dequeuing channel 3 returns 0x22 three times without disturbing channel 0.
- SIZE=5 wrap: fill channel 1 with values 1..5, then loop dequeue-one/enqueue-one 12 times → data order is preserved across the wrap and count[1] stays 5.
- Simultaneous enqueue and dequeue on the same full channel → count unchanged, full stays 1, head value advances, no overflow.
- flush_mask=4'b0010 with enqueue_en to channel 1 and dequeue_en from channel 0 in the same cycle → count[1]=0; channel 0 count decrements by 1.
- With MULTI_CHANNEL_FIFO_ERROR_CHECK_EN: enqueue to a full channel → overflow=1 and count stays SIZE; dequeue from an empty channel → underflow=1; both flags clear only when reset is asserted mid-test.
